// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor: retries the PLL until lock, debounces lock,
// then releases the core resets in stages and drops them all again on lock loss.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGES         = 3,
    parameter int STAGE_GAP      = 64
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              soft_rst,
    output logic              pll_rst,
    output logic [STAGES-1:0] core_rst_n,
    output logic              ready,
    output logic [7:0]        retry_cnt,
    output logic [7:0]        unlock_cnt,
    output logic [2:0]        state
);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX_B = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] C_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(STAGE_GAP - 1);

    logic              r_sync1;
    logic              r_lk;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pll_rst;
    logic [STAGES-1:0] r_core_rst_n;
    logic              r_ready;
    logic [7:0]        r_retry_cnt;
    logic [7:0]        r_unlock_cnt;

    // Next staged-release pattern: shift in one more released bit from the bottom.
    logic [STAGES-1:0] w_core_next;
    logic              w_last_stage;

    assign w_core_next  = STAGES'({r_core_rst_n, 1'b1});
    assign w_last_stage = w_core_next[STAGES-1];

    // Two-flop synchroniser for the asynchronous lock indicator.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_lk    <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_lk    <= r_sync1;
        end
    end

    // Supervisor state machine with registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PLL_RST;
            r_cnt        <= C_ZERO;
            r_pll_rst    <= 1'b1;
            r_core_rst_n <= {STAGES{1'b0}};
            r_ready      <= 1'b0;
            r_retry_cnt  <= 8'd0;
            r_unlock_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == C_PLL_LAST) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_cnt     <= C_ZERO;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lk) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= C_ZERO;
                    end else if (r_cnt == C_TO_LAST) begin
                        r_state   <= ST_PLL_RST;
                        r_pll_rst <= 1'b1;
                        r_cnt     <= C_ZERO;
                        if (r_retry_cnt != 8'hFF) begin
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                        end else begin
                            r_retry_cnt <= r_retry_cnt;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!r_lk) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= C_ZERO;
                    end else if (r_cnt == C_STB_LAST) begin
                        // Stage 0 is released on the RELEASE-entry edge itself.
                        r_core_rst_n <= w_core_next;
                        r_cnt        <= C_ZERO;
                        if (w_last_stage) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (!r_lk) begin
                        r_state      <= ST_WAIT_LOCK;
                        r_cnt        <= C_ZERO;
                        r_core_rst_n <= {STAGES{1'b0}};
                        r_ready      <= 1'b0;
                        if (r_unlock_cnt != 8'hFF) begin
                            r_unlock_cnt <= r_unlock_cnt + 8'd1;
                        end else begin
                            r_unlock_cnt <= r_unlock_cnt;
                        end
                    end else if (soft_rst) begin
                        // Preloading the gap count makes stage 0 release on the following edge.
                        r_state      <= ST_RELEASE;
                        r_cnt        <= C_GAP_LAST;
                        r_core_rst_n <= {STAGES{1'b0}};
                        r_ready      <= 1'b0;
                    end else if (r_state == ST_RUN) begin
                        r_cnt <= C_ZERO;
                    end else if (r_cnt == C_GAP_LAST) begin
                        r_core_rst_n <= w_core_next;
                        r_cnt        <= C_ZERO;
                        if (w_last_stage) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state      <= ST_PLL_RST;
                    r_cnt        <= C_ZERO;
                    r_pll_rst    <= 1'b1;
                    r_core_rst_n <= {STAGES{1'b0}};
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst    = r_pll_rst;
    assign core_rst_n = r_core_rst_n;
    assign ready      = r_ready;
    assign retry_cnt  = r_retry_cnt;
    assign unlock_cnt = r_unlock_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued with a due
// cycle when stimulus is applied and compared on the falling edge of that cycle.
module tb_pll_reset_sequencer;

    localparam int PRC = 8;
    localparam int LTO = 64;
    localparam int LST = 16;
    localparam int STG = 3;
    localparam int GAP = 4;

    localparam int F_STATE  = 0;
    localparam int F_CORE   = 1;
    localparam int F_READY  = 2;
    localparam int F_PLLRST = 3;
    localparam int F_RETRY  = 4;
    localparam int F_UNLOCK = 5;

    logic           clk_sys    = 1'b0;
    logic           rst_n      = 1'b0;
    logic           pll_locked = 1'b0;
    logic           soft_rst   = 1'b0;
    logic           pll_rst;
    logic [STG-1:0] core_rst_n;
    logic           ready;
    logic [7:0]     retry_cnt;
    logic [7:0]     unlock_cnt;
    logic [2:0]     state;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .LOCK_STABLE   (LST),
        .STAGES        (STG),
        .STAGE_GAP     (GAP)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .soft_rst  (soft_rst),
        .pll_rst   (pll_rst),
        .core_rst_n(core_rst_n),
        .ready     (ready),
        .retry_cnt (retry_cnt),
        .unlock_cnt(unlock_cnt),
        .state     (state)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retry  = 0;
    int exp_unlock = 0;

    typedef struct {
        string       tag;
        int          due;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] field_val(input int f);
        case (f)
            F_STATE:  return {29'd0, state};
            F_CORE:   return {29'd0, core_rst_n};
            F_READY:  return {31'd0, ready};
            F_PLLRST: return {31'd0, pll_rst};
            F_RETRY:  return {24'd0, retry_cnt};
            F_UNLOCK: return {24'd0, unlock_cnt};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input string tag, input int due, input int fld, input int val);
        exp_t e;
        int   pos;
        e.tag = tag;
        e.due = due;
        e.fld = fld;
        e.val = val;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].due > due) pos--;
        sb.insert(pos, e);
    endtask

    // Compare every expectation that falls due on this cycle.
    always @(negedge clk_sys) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m_e = sb.pop_front();
            if (m_e.due == cyc) begin
                check(m_e.tag, field_val(m_e.fld), m_e.val);
            end else begin
                check({m_e.tag, "_late"}, cyc, m_e.due);
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_sys);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_state"},  {29'd0, state},      32'd0);
        check({tag, "_pllrst"}, {31'd0, pll_rst},    32'd1);
        check({tag, "_core"},   {29'd0, core_rst_n}, 32'd0);
        check({tag, "_ready"},  {31'd0, ready},      32'd0);
        check({tag, "_retry"},  {24'd0, retry_cnt},  32'd0);
        check({tag, "_unlock"}, {24'd0, unlock_cnt}, 32'd0);
    endtask

    // pll_locked raised at the falling edge of cycle x, with the FSM waiting for lock.
    task automatic push_release(input string tag, input int x);
        expect_at({tag, "_wait"},     x + 2,  F_STATE,  1);
        expect_at({tag, "_stable"},   x + 3,  F_STATE,  2);
        expect_at({tag, "_core_pre"}, x + 18, F_CORE,   0);
        expect_at({tag, "_core1"},    x + 19, F_CORE,   1);
        expect_at({tag, "_release"},  x + 19, F_STATE,  3);
        expect_at({tag, "_core1b"},   x + 22, F_CORE,   1);
        expect_at({tag, "_core3"},    x + 23, F_CORE,   3);
        expect_at({tag, "_rdy_pre"},  x + 26, F_READY,  0);
        expect_at({tag, "_core7"},    x + 27, F_CORE,   7);
        expect_at({tag, "_ready"},    x + 27, F_READY,  1);
        expect_at({tag, "_run"},      x + 27, F_STATE,  4);
        expect_at({tag, "_pllrst"},   x + 27, F_PLLRST, 0);
        expect_at({tag, "_retry"},    x + 27, F_RETRY,  exp_retry);
        expect_at({tag, "_unlock"},   x + 27, F_UNLOCK, exp_unlock);
    endtask

    initial begin
        int c0;
        int b;
        int s;
        int d;
        int x;
        int c;
        int c2;

        // Reset values, then a clean first lock.
        repeat (3) @(negedge clk_sys);
        reset_checks("rst0");
        rst_n = 1'b1;
        c0 = cyc;
        expect_at("s1_pllrst_hi", c0 + 7, F_PLLRST, 1);
        expect_at("s1_pllrst_lo", c0 + 8, F_PLLRST, 0);
        expect_at("s1_wait",      c0 + 8, F_STATE,  1);
        wait_cyc(c0 + 19);
        pll_locked = 1'b1;
        push_release("s1", c0 + 19);
        drain(100);

        // Lock loss in RUN, then relock.
        b = cyc;
        pll_locked = 1'b0;
        exp_unlock++;
        expect_at("s4_core_hold", b + 2, F_CORE,   7);
        expect_at("s4_rdy_hold",  b + 2, F_READY,  1);
        expect_at("s4_core0",     b + 3, F_CORE,   0);
        expect_at("s4_ready0",    b + 3, F_READY,  0);
        expect_at("s4_wait",      b + 3, F_STATE,  1);
        expect_at("s4_pllrst",    b + 3, F_PLLRST, 0);
        expect_at("s4_unlock",    b + 3, F_UNLOCK, exp_unlock);
        wait_cyc(b + 5);
        pll_locked = 1'b1;
        push_release("s4r", b + 5);
        drain(100);

        // One-cycle soft reset in RUN.
        s = cyc;
        soft_rst = 1'b1;
        @(negedge clk_sys);
        soft_rst = 1'b0;
        expect_at("s5_core0",   s + 1,  F_CORE,   0);
        expect_at("s5_ready0",  s + 1,  F_READY,  0);
        expect_at("s5_release", s + 1,  F_STATE,  3);
        expect_at("s5_core1",   s + 2,  F_CORE,   1);
        expect_at("s5_core1b",  s + 5,  F_CORE,   1);
        expect_at("s5_core3",   s + 6,  F_CORE,   3);
        expect_at("s5_core7",   s + 10, F_CORE,   7);
        expect_at("s5_ready",   s + 10, F_READY,  1);
        expect_at("s5_run",     s + 10, F_STATE,  4);
        expect_at("s5_unlock",  s + 10, F_UNLOCK, exp_unlock);
        drain(100);

        // soft_rst coinciding with lock loss: lock loss wins.
        d = cyc;
        pll_locked = 1'b0;
        exp_unlock++;
        expect_at("s5b_core_hold", d + 2, F_CORE,   7);
        expect_at("s5b_wait",      d + 3, F_STATE,  1);
        expect_at("s5b_core0",     d + 3, F_CORE,   0);
        expect_at("s5b_unlock",    d + 3, F_UNLOCK, exp_unlock);
        wait_cyc(d + 2);
        soft_rst = 1'b1;
        wait_cyc(d + 3);
        soft_rst = 1'b0;

        // Relock with a one-cycle glitch partway through STABLE.
        x = d + 5;
        wait_cyc(x);
        pll_locked = 1'b1;
        expect_at("s3_stable",     x + 3,  F_STATE,  2);
        expect_at("s3_stable_pre", x + 14, F_STATE,  2);
        expect_at("s3_back_wait",  x + 15, F_STATE,  1);
        expect_at("s3_restable",   x + 16, F_STATE,  2);
        expect_at("s3_still_stab", x + 31, F_STATE,  2);
        expect_at("s3_core_pre",   x + 31, F_CORE,   0);
        expect_at("s3_core1",      x + 32, F_CORE,   1);
        expect_at("s3_release",    x + 32, F_STATE,  3);
        expect_at("s3_core7",      x + 40, F_CORE,   7);
        expect_at("s3_run",        x + 40, F_STATE,  4);
        expect_at("s3_retry",      x + 40, F_RETRY,  exp_retry);
        expect_at("s3_unlock",     x + 40, F_UNLOCK, exp_unlock);
        wait_cyc(x + 12);
        pll_locked = 1'b0;
        wait_cyc(x + 13);
        pll_locked = 1'b1;
        drain(100);

        // No lock at all: periodic PLL retries and saturating retry count.
        pll_locked = 1'b0;
        rst_n = 1'b0;
        exp_retry  = 0;
        exp_unlock = 0;
        repeat (2) @(negedge clk_sys);
        reset_checks("rst2");
        rst_n = 1'b1;
        c = cyc;
        expect_at("s2_pllrst_hi0", c + 7,   F_PLLRST, 1);
        expect_at("s2_pllrst_lo0", c + 8,   F_PLLRST, 0);
        expect_at("s2_wait",       c + 8,   F_STATE,  1);
        expect_at("s2_pllrst_lo1", c + 71,  F_PLLRST, 0);
        expect_at("s2_retry0",     c + 71,  F_RETRY,  0);
        expect_at("s2_pllrst_hi1", c + 72,  F_PLLRST, 1);
        expect_at("s2_retry1",     c + 72,  F_RETRY,  1);
        expect_at("s2_pllrst_st",  c + 72,  F_STATE,  0);
        expect_at("s2_pllrst_hi2", c + 79,  F_PLLRST, 1);
        expect_at("s2_pllrst_lo2", c + 80,  F_PLLRST, 0);
        expect_at("s2_retry2",     c + 144, F_RETRY,  2);
        expect_at("s2_pllrst_hi3", c + 144, F_PLLRST, 1);
        expect_at("s2_retry3",     c + 216, F_RETRY,  3);
        expect_at("s2_core0",      c + 216, F_CORE,   0);
        expect_at("s2_retry254",   c + 287, F_RETRY,  254);
        expect_at("s2_retry255",   c + 288, F_RETRY,  255);
        expect_at("s2_retry_sat",  c + 360, F_RETRY,  255);
        expect_at("s2_core0b",     c + 360, F_CORE,   0);
        wait_cyc(c + 220);
        force dut.r_retry_cnt = 8'd254;
        #1;
        release dut.r_retry_cnt;
        drain(400);

        // Asynchronous reset in the middle of RELEASE.
        x = c + 370;
        wait_cyc(x);
        pll_locked = 1'b1;
        expect_at("s6_core1", x + 19, F_CORE,  1);
        expect_at("s6_rel",   x + 19, F_STATE, 3);
        expect_at("s6_core3", x + 23, F_CORE,  3);
        drain(100);
        wait_cyc(x + 24);
        check("s6_pre_state", {29'd0, state}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("s6_async");
        @(negedge clk_sys);
        rst_n = 1'b1;
        c2 = cyc;
        expect_at("s6_pllrst_hi", c2 + 7,  F_PLLRST, 1);
        expect_at("s6_pllrst_st", c2 + 7,  F_STATE,  0);
        expect_at("s6_pllrst_lo", c2 + 8,  F_PLLRST, 0);
        expect_at("s6_wait",      c2 + 8,  F_STATE,  1);
        expect_at("s6_stable",    c2 + 9,  F_STATE,  2);
        expect_at("s6_re_core1",  c2 + 25, F_CORE,   1);
        expect_at("s6_re_rel",    c2 + 25, F_STATE,  3);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
